// File: rtl/xor_accum_pkg.sv
// Shared types and constants for the XOR accumulator scheduler.
package xor_accum_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam int N_REQ_DEF     = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int BURST_LEN_DEF = 4;
  localparam int CNT_W         = 8;
endpackage

// File: rtl/xor_rr_arbiter.sv
// Combinational round-robin pick: search upward from last_winner+1, wrapping.
module xor_rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);
  int   cand;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    // k = N_REQ wraps back to last_winner itself, so a lone repeat requester still wins
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_winner) + k) % N_REQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end
endmodule

// File: rtl/xor_accum_sched.sv
// Burst scheduler: grants one requester at a time and XORs BURST_LEN words into a result.
// Optional parity output enabled by defining XOR_ACCUM_PARITY_EN.
module xor_accum_sched
  import xor_accum_pkg::*;
#(
  parameter  int N_REQ     = N_REQ_DEF,
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int BURST_LEN = BURST_LEN_DEF,
  localparam int IDX_W     = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          valid,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
  output logic [N_REQ-1:0]          ready,
  output logic [N_REQ-1:0]          gnt,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_W-1:0]         result,
  output logic [IDX_W-1:0]          result_id
`ifdef XOR_ACCUM_PARITY_EN
  ,output logic                     parity
`endif
);
  state_t             state, state_nxt;
  logic [N_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx, owner, last_winner;
  logic [DATA_W-1:0]  acc, word, acc_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               hs, last_word, owner_req;

  xor_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req         (req),
    .last_winner (last_winner),
    .gnt         (arb_gnt),
    .idx         (arb_idx)
  );

  assign word      = data_in[owner*DATA_W +: DATA_W];
  assign acc_nxt   = acc ^ word;
  assign hs        = |(valid & gnt);
  assign last_word = hs && (cnt == CNT_W'(BURST_LEN-1));
  assign owner_req = req[owner];
  assign ready     = gnt;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ACCUM;
      // final handshake outranks a simultaneous req drop
      ACCUM:   if (last_word) state_nxt = DONE;
               else if (!owner_req) state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= '0;
      owner       <= '0;
      last_winner <= IDX_W'(N_REQ-1);
      acc         <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      result      <= '0;
      result_id   <= '0;
`ifdef XOR_ACCUM_PARITY_EN
      parity      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          gnt   <= arb_gnt;
          owner <= arb_idx;
          acc   <= '0;
          cnt   <= '0;
        end
        ACCUM: begin
          if (last_word) begin
            gnt       <= '0;
            done      <= 1'b1;
            result    <= acc_nxt;
            result_id <= owner;
`ifdef XOR_ACCUM_PARITY_EN
            parity    <= ^acc_nxt;
`endif
          end else if (!owner_req) begin
            gnt         <= '0;
            last_winner <= owner;
          end else if (hs) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    last_winner <= owner;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/xor_accum_sched.md
XOR_ACCUM_SCHED -- requirements
Module: xor_accum_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the XOR accumulator (2..8).
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 Parameter BURST_LEN, default 4, words per burst (1..255).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset is synchronous and active-low.
REQ-006 req  input  N_REQ  per-requester burst request, held high for the whole burst.
REQ-007 valid  input  N_REQ  per-requester data-valid.
REQ-008 data_in  input  N_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 ready  output  N_REQ  word accepted for requester i when valid[i]&ready[i].
REQ-010 gnt  output  N_REQ  one-hot current owner, all-zero when idle.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse; burst result valid.
REQ-013 result  output  DATA_W  XOR of all words of the last completed burst; held until the next done.
REQ-014 result_id  output  clog2(N_REQ)  index of the requester that owned the last completed burst.

Function
REQ-015 FSM states IDLE, ACCUM, DONE; registered state, registered outputs.
REQ-016 IDLE: if any req bit is set, select winner round-robin, searching upward from (last_winner+1) mod N_REQ; load gnt, clear acc and cnt; next state ACCUM. Otherwise stay in IDLE.
REQ-017 ACCUM: ready = gnt; each handshake sets acc <= acc ^ word, cnt <= cnt+1.
REQ-018 ACCUM: handshake with cnt == BURST_LEN-1 -> DONE; result <= acc ^ word; result_id <= owner.
REQ-019 DONE: done=1 for exactly one cycle; gnt and ready cleared; last_winner <= owner; next state IDLE.
REQ-020 Minimum latency: done asserts one cycle after the final handshake; back-to-back bursts cost one IDLE cycle.
REQ-021 ACCUM with valid low: no state change (stall tolerated indefinitely).
REQ-022 Owner drops req in ACCUM before its final word -> abort: return to IDLE, no done, result/result_id unchanged, last_winner <= owner.
REQ-023 If req and the final handshake occur in the same cycle, the final handshake wins and the burst completes normally.
REQ-024 ready and gnt SHALL never be asserted for a non-owner; valid from non-owners is ignored.
REQ-025 cnt width = 8 bits; it never wraps, because the burst ends at BURST_LEN-1.

Reset
REQ-026 rst_n low at a clock edge: state IDLE, gnt/ready/done/busy 0, result 0, result_id 0, acc/cnt 0, last_winner N_REQ-1 (requester 0 wins first).
REQ-027 Reset mid-burst discards the partial accumulation with no done pulse.

Configuration
REQ-028 Macro XOR_ACCUM_PARITY_EN defined: add output parity (1 bit) = reduction XOR of result, registered with result and held with it.
REQ-029 Macro undefined: no parity port and no parity logic; all other behaviour identical.

Structure
REQ-030 Package xor_accum_pkg holds the state enum (IDLE/ACCUM/DONE), default parameter constants and the cnt width constant.
REQ-031 Round-robin selection lives in sub-module xor_rr_arbiter (inputs req, last_winner; outputs one-hot gnt, index); it is purely combinational.

Verification
REQ-032 Reset, then req=0001 with words 0x0F,0xF0,0xAA,0x55 sent on consecutive cycles -> done one cycle after the 4th handshake, result=0x00, result_id=0.
REQ-033 req=1111 held -> grants in order 0,1,2,3,0 across consecutive bursts; each done carries matching result_id.
REQ-034 Owner 2 sends 0x01,0x02, then valid low for 5 cycles, then 0x04,0x08 -> result=0x0F, no early done.
REQ-035 Owner 1 drops req after 2 words -> no done, busy low next cycle, previous result held, next grant goes to requester 2 if it is requesting.
REQ-036 rst_n low during ACCUM -> outputs 0 next cycle; new burst from requester 0 produces the correct fresh XOR.
REQ-037 With XOR_ACCUM_PARITY_EN: burst 0x01,0x00,0x00,0x00 -> result=0x01, parity=1; burst 0x03,0,0,0 -> parity=0.
